// File: rtl/fpga_status_led_if.sv
// fpga_status_led_if
// Bundles the per-channel LED control and status signals of fpga_status_led.
//   led_mode     [2*LED_COUNT] per-channel mode (00 off, 01 on, 10 activity, 11 error)
//   activity     [LED_COUNT]   single-cycle activity strobes
//   error        [LED_COUNT]   single-cycle error strobes (set sticky flag)
//   error_clear  [LED_COUNT]   single-cycle sticky-flag clear strobes
//   error_status [LED_COUNT]   registered sticky error flags
//   led_out      [LED_COUNT]   registered LED drive
// master: the controlling logic (drives modes/strobes); slave: fpga_status_led.
interface fpga_status_led_if #(
  parameter int LED_COUNT = 4
);
  logic [2*LED_COUNT-1:0] led_mode;
  logic [LED_COUNT-1:0]   activity;
  logic [LED_COUNT-1:0]   error;
  logic [LED_COUNT-1:0]   error_clear;
  logic [LED_COUNT-1:0]   error_status;
  logic [LED_COUNT-1:0]   led_out;

  modport master (
    output led_mode, activity, error, error_clear,
    input  error_status, led_out
  );

  modport slave (
    input  led_mode, activity, error, error_clear,
    output error_status, led_out
  );
endinterface

// File: rtl/fpga_status_led.sv
// fpga_status_led
// Board status indicator: LED_COUNT channels, each with a runtime mode of
// off, steady on, pulse-stretched activity, or sticky-error blink. All timing
// derives from one shared prescaled tick.
//   clk  core clock
//   rst  synchronous reset, active high
//   bus  fpga_status_led_if.slave (modes, strobes, error_status, led_out)
module fpga_status_led #(
  parameter int TICK_DIV       = 250000,
  parameter int STRETCH_TICKS  = 50,
  parameter int BLINK_TICKS    = 250,
  parameter int LED_COUNT      = 4,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  fpga_status_led_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int SW = $clog2(STRETCH_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_TICKS - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_TICKS);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_ACT   = 2'b10;
  localparam logic [1:0] MODE_ERROR = 2'b11;

  localparam logic [LED_COUNT-1:0] LED_OFF = {LED_COUNT{LED_ACTIVE_LOW}};

  logic [TW-1:0]          r_tick_cnt;
  logic                   r_tick;
  logic [BW-1:0]          r_blink_cnt;
  logic                   r_blink_phase;
  logic [SW-1:0]          r_stretch [LED_COUNT];
  logic [LED_COUNT-1:0]   r_err;
  logic [LED_COUNT-1:0]   r_led;
  logic [LED_COUNT-1:0]   w_lit;

  // Prescaler: tick is registered, so it lands the cycle after the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= (r_tick_cnt == TICK_LAST);
      if (r_tick_cnt == TICK_LAST) r_tick_cnt <= '0;
      else                         r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_tick) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Stretch counters run in every mode; a strobe reloads even on a tick.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LED_COUNT; i++) begin
      if (rst)                                 r_stretch[i] <= '0;
      else if (bus.activity[i])                r_stretch[i] <= STRETCH_LOAD;
      else if (r_tick && (r_stretch[i] != '0)) r_stretch[i] <= r_stretch[i] - 1'b1;
    end
  end

  // Sticky error: set dominates clear.
  always_ff @(posedge clk) begin
    if (rst) r_err <= '0;
    else     r_err <= bus.error | (r_err & ~bus.error_clear);
  end

  always_comb begin
    w_lit = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      unique case (bus.led_mode[2*i +: 2])
        MODE_OFF:   w_lit[i] = 1'b0;
        MODE_ON:    w_lit[i] = 1'b1;
        MODE_ACT:   w_lit[i] = (r_stretch[i] != '0);
        MODE_ERROR: w_lit[i] = r_err[i] ? r_blink_phase : 1'b1;
        default:    w_lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_led <= LED_OFF;
    else     r_led <= w_lit ^ LED_OFF;
  end

  assign bus.error_status = r_err;
  assign bus.led_out      = r_led;

endmodule
